// File: rtl/multi_timer.sv
// multi_timer: N_CH independent programmable interval timers with periodic or
// one-shot mode, pause via en, sticky irq with acknowledge, and a per-terminal
// expire pulse.
// Optional build macro MULTI_TIMER_PRESCALE_EN adds a shared prescaler so each
// channel advances once every PRESCALE clocks instead of every clock.
module multi_timer #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 50,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_we,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   mode,
  input  logic [N_CH-1:0]   irq_ack,
  output logic [N_CH-1:0]   expire,
  output logic [N_CH-1:0]   irq,
  output logic [N_CH-1:0]   running,
  output logic              irq_any
);

  // Elaboration-time parameter sanity checks.
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("multi_timer: N_CH must be in 1..16");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("multi_timer: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] div [N_CH];
  logic [WIDTH-1:0] acc [N_CH];
  logic [N_CH-1:0]  done;
  logic             tick;
  logic [N_CH-1:0]  load_hit;
  logic [N_CH-1:0]  counting;
  logic [N_CH-1:0]  terminal;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pre;

  // Shared free-running prescaler; loads never disturb its phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (pre == PS_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PS_W'(1);
    end
  end

  assign tick = (pre == PS_LAST);
`else
  assign tick = 1'b1;
`endif

  // Per-channel write decode and terminal-count detection.
  always_comb begin
    load_hit = '0;
    counting = '0;
    terminal = '0;
    for (int c = 0; c < N_CH; c++) begin
      // Out-of-range channel indices match no channel and are dropped.
      load_hit[c] = load_we && (load_ch == CH_W'(c));
      counting[c] = en[c] & tick & ~done[c];
      terminal[c] = counting[c] && (acc[c] == div[c]);
    end
  end

  // Channel state: load beats terminal, terminal beats plain counting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        div[c] <= '0;
        acc[c] <= '0;
      end
      done   <= '0;
      irq    <= '0;
      expire <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        // A load in the terminal cycle swallows that cycle's expire and irq set;
        // a simultaneous set and ack leaves irq high.
        expire[c] <= terminal[c] & ~load_hit[c];
        irq[c]    <= (terminal[c] & ~load_hit[c]) | (irq[c] & ~irq_ack[c]);
        if (load_hit[c]) begin
          div[c]  <= load_val;
          acc[c]  <= '0;
          done[c] <= 1'b0;
        end else if (terminal[c]) begin
          acc[c] <= '0;
          if (mode[c]) begin
            done[c] <= 1'b1;
          end
        end else if (counting[c]) begin
          acc[c] <= acc[c] + WIDTH'(1);
        end
      end
    end
  end

  assign running = en & ~done;
  assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: table of single-channel timing scenarios
// plus hand-written sequences for reload, ack, load-at-terminal and reset cases.
// Expected bits are queued before each clock edge and checked just after it.
module tb_multi_timer;

  localparam int N_CH  = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load_we;
  logic [1:0]       load_ch;
  logic [WIDTH-1:0] load_val;
  logic [N_CH-1:0]  en, mode, irq_ack;
  logic [N_CH-1:0]  expire, irq, running;
  logic             irq_any;

  multi_timer #(.N_CH(N_CH), .WIDTH(WIDTH), .PRESCALE(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_we  (load_we),
    .load_ch  (load_ch),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .irq_ack  (irq_ack),
    .expire   (expire),
    .irq      (irq),
    .running  (running),
    .irq_any  (irq_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sig;   // 0 expire, 1 irq, 2 running, 3 irq_any
    int    ch;
    logic  val;
  } chk_t;

  typedef struct {
    string name;
    int    ch;
    int    div;
    bit    mode;
    int    pause_at;   // acc value after which en is dropped, -1 for none
    int    pause_len;
    int    win;
    int    e0, e1, e2; // edges after the load edge that carry expire
  } vec_t;

  chk_t sbq[$];
  vec_t tbl[4];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic exp_bit(string nm, int sig, int ch, logic v);
    chk_t e;
    e.name = nm; e.sig = sig; e.ch = ch; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic exp_ch(string nm, int ch, logic ex, logic iq, logic rn);
    exp_bit({nm, "_expire"}, 0, ch, ex);
    exp_bit({nm, "_irq"}, 1, ch, iq);
    exp_bit({nm, "_running"}, 2, ch, rn);
  endtask

  function automatic logic get_sig(int sig, int ch);
    case (sig)
      0:       return expire[ch];
      1:       return irq[ch];
      2:       return running[ch];
      default: return irq_any;
    endcase
  endfunction

  // Advance one edge and drain the scoreboard against the settled outputs.
  task automatic cycle();
    chk_t e;
    logic a;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = get_sig(e.sig, e.ch);
      n_vec++;
      if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s ch%0d: got %b expected %b at %0t", e.name, e.ch, a, e.val, $time);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load_we = 1'b0; load_ch = '0; load_val = '0;
    en = '0; mode = '0; irq_ack = '0;
    for (int c = 0; c < N_CH; c++) exp_ch("reset", c, 1'b0, 1'b0, 1'b0);
    exp_bit("reset_irq_any", 3, 0, 1'b0);
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic load(int ch, int v);
    load_we  = 1'b1;
    load_ch  = 2'(ch);
    load_val = WIDTH'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"periodic4", 0, 4, 1'b0, -1, 0, 16, 5, 10, 15};
    tbl[1] = '{"oneshot2",  1, 2, 1'b1, -1, 0, 23, 3, -1, -1};
    tbl[2] = '{"pause9",    2, 9, 1'b0,  5, 7, 20, 17, -1, -1};
    tbl[3] = '{"periodic3", 3, 3, 1'b0, -1, 0, 9, 4, 8, -1};

`ifdef MULTI_TIMER_PRESCALE_EN
    begin
      bit found;
      found = 1'b0;
      do_reset();
      en[0] = 1'b1;
      load(0, 1);
      cycle();
      load_we = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        cycle();
        if (expire[0] === 1'b1) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
        n_bad++;
        $display("FAIL prescale_first: got no expire expected one within 40 cycles");
      end
      for (int j = 1; j <= 20; j++) begin
        exp_ch("prescale", 0, (j == 10 || j == 20), 1'b1, 1'b1);
        cycle();
      end
    end
`else
    // Table-driven single-channel scenarios, each from a fresh reset.
    for (int r = 0; r < 4; r++) begin
      logic pz, hit;
      do_reset();
      mode[tbl[r].ch] = tbl[r].mode;
      en[tbl[r].ch]   = 1'b1;
      load(tbl[r].ch, tbl[r].div);
      exp_ch({tbl[r].name, "_load"}, tbl[r].ch, 1'b0, 1'b0, 1'b1);
      cycle();
      load_we = 1'b0;
      for (int j = 1; j <= tbl[r].win; j++) begin
        pz = (tbl[r].pause_at >= 0) && (j > tbl[r].pause_at) &&
             (j <= tbl[r].pause_at + tbl[r].pause_len);
        en[tbl[r].ch] = !pz;
        hit = (j == tbl[r].e0) || (j == tbl[r].e1) || (j == tbl[r].e2);
        exp_ch(tbl[r].name, tbl[r].ch, hit, (j >= tbl[r].e0),
               !pz && !(tbl[r].mode && j >= tbl[r].e0));
        cycle();
      end
    end

    // One-shot: en toggle does not re-arm, reload does.
    do_reset();
    mode[1] = 1'b1; en[1] = 1'b1;
    load(1, 2);
    cycle();
    load_we = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      exp_ch("os_first", 1, (j == 3), (j >= 3), (j < 3));
      cycle();
    end
    en[1] = 1'b0;
    exp_ch("os_en_off", 1, 1'b0, 1'b1, 1'b0);
    cycle();
    en[1] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      exp_ch("os_no_rearm", 1, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    load(1, 2);
    exp_ch("os_reload", 1, 1'b0, 1'b1, 1'b1);
    cycle();
    load_we = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      exp_ch("os_second", 1, (j == 3), 1'b1, (j < 3));
      cycle();
    end

    // div=0 periodic with ack held: expire every cycle, set beats ack.
    do_reset();
    en[0] = 1'b1; irq_ack[0] = 1'b1;
    load(0, 0);
    exp_ch("div0_load", 0, 1'b0, 1'b0, 1'b1);
    cycle();
    load_we = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      exp_ch("div0", 0, 1'b1, 1'b1, 1'b1);
      exp_bit("div0_irq_any", 3, 0, 1'b1);
      cycle();
    end
    en[0] = 1'b0;
    exp_ch("ack_clear", 0, 1'b0, 1'b0, 1'b0);
    exp_bit("ack_clear_irq_any", 3, 0, 1'b0);
    cycle();
    irq_ack[0] = 1'b0;

    // Load landing on the terminal cycle suppresses expire and restarts.
    do_reset();
    en[3] = 1'b1;
    load(3, 3);
    cycle();
    load_we = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      exp_ch("lt_pre", 3, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    load(3, 3);
    exp_ch("lt_suppress", 3, 1'b0, 1'b0, 1'b1);
    cycle();
    load_we = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      exp_ch("lt_after", 3, (j == 4), (j >= 4), 1'b1);
      cycle();
    end

    // Mid-count reset clears everything, including the divider.
    reset_n = 1'b0;
    exp_bit("midreset_expire", 0, 3, 1'b0);
    exp_bit("midreset_irq", 1, 3, 1'b0);
    exp_bit("midreset_irq_any", 3, 0, 1'b0);
    cycle();
    reset_n = 1'b1;
    en[3] = 1'b0;
    exp_ch("post_reset_idle", 3, 1'b0, 1'b0, 1'b0);
    cycle();
    en[3] = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      exp_ch("post_reset_div0", 3, 1'b1, 1'b1, 1'b1);
      cycle();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
